vedic_mult_seq_ctrl: RTL and testbench

- Sequential 8x8 unsigned multiplier controller. One 12-bit adder is time-shared across three cycles, with the same 12-bit wrap-around semantics as the team's combinational adder.
- Four 4x4 partial products are formed from registered operand nibbles. A small FSM schedules them through the single adder.
- Sits between an upstream operand source and a downstream consumer, with valid/ready handshakes on both sides.
- Area-reduced alternative to the fully parallel 8-bit Vedic multiplier.

---
 rtl/vedic_mult_seq_ctrl_if.sv | 31 +++
 rtl/vedic_mult_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_vedic_mult_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vedic_mult_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : vedic_mult_seq_ctrl_if
//  Brief    : Operand-in / product-out valid-ready bundle for the sequential
//             8x8 Vedic multiplier controller.
//  Revision : 1.0  initial release
// ============================================================================
interface vedic_mult_seq_ctrl_if;
    // Upstream operand channel
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    // Downstream product channel
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    // Environment side: sources operands, sinks products
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    // Multiplier side
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface
`default_nettype wire

// File: rtl/vedic_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vedic_mult_seq_ctrl
//  Brief    : Sequential 8x8 unsigned multiplier. Four 4x4 partial products
//             from the registered operand nibbles are folded through a single
//             time-shared 12-bit adder over three cycles (ADD1..ADD3).
//             Optional zero-operand bypass skips the add sequence.
//  Revision : 1.0  initial release
// ============================================================================
module vedic_mult_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    vedic_mult_seq_ctrl_if.slave      bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADD1 = 3'd1;
    localparam logic [2:0] S_ADD2 = 3'd2;
    localparam logic [2:0] S_ADD3 = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  r_state;
    logic [7:0]  r_ra;
    logic [7:0]  r_rb;
    logic [11:0] r_acc;
    logic [15:0] r_product;

    logic [7:0]  w_pp0;
    logic [7:0]  w_pp1;
    logic [7:0]  w_pp2;
    logic [7:0]  w_pp3;
    logic [11:0] w_opx;
    logic [11:0] w_opy;
    logic [11:0] w_sum;
    logic        w_accept;
    logic        w_bypass;

    // Nibble partial products; zero-extended so each multiply is 8 bits wide
    assign w_pp0 = {4'b0, r_ra[3:0]} * {4'b0, r_rb[3:0]};
    assign w_pp1 = {4'b0, r_ra[7:4]} * {4'b0, r_rb[3:0]};
    assign w_pp2 = {4'b0, r_ra[3:0]} * {4'b0, r_rb[7:4]};
    assign w_pp3 = {4'b0, r_ra[7:4]} * {4'b0, r_rb[7:4]};

    // Operands are only sampled in IDLE; elsewhere a/b/in_valid are ignored
    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_bypass = SKIP_ZERO && ((bus.a == 8'd0) || (bus.b == 8'd0));

    // Adder operand select; the upper-sum never exceeds 4064 so no carry-out
    always_comb begin
        w_opx = 12'd0;
        w_opy = 12'd0;
        case (r_state)
            S_ADD1: begin
                w_opx = {4'b0, w_pp1};
                w_opy = {4'b0, w_pp2};
            end
            S_ADD2: begin
                w_opx = r_acc;
                w_opy = {8'b0, w_pp0[7:4]};
            end
            S_ADD3: begin
                w_opx = r_acc;
                w_opy = {w_pp3, 4'b0};
            end
            default: begin
                w_opx = 12'd0;
                w_opy = 12'd0;
            end
        endcase
    end

    // The single shared 12-bit adder (wraps mod 4096)
    assign w_sum = w_opx + w_opy;

    // Sequencer: operand capture, accumulation and product register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ra      <= 8'd0;
            r_rb      <= 8'd0;
            r_acc     <= 12'd0;
            r_product <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ra <= bus.a;
                        r_rb <= bus.b;
                        if (w_bypass) begin
                            r_acc     <= 12'd0;
                            r_product <= 16'd0;
                            r_state   <= S_DONE;
                        end else begin
                            r_state   <= S_ADD1;
                        end
                    end
                end
                S_ADD1: begin
                    r_acc   <= w_sum;
                    r_state <= S_ADD2;
                end
                S_ADD2: begin
                    r_acc   <= w_sum;
                    r_state <= S_ADD3;
                end
                S_ADD3: begin
                    r_product <= {w_sum, w_pp0[3:0]};
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode directly from the registered state
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_vedic_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vedic_mult_seq_ctrl
//  Brief    : Scoreboard bench for vedic_mult_seq_ctrl. Two instances: one
//             with zero bypass (bus1) and one without (bus0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_vedic_mult_seq_ctrl;

    logic clk;
    logic rst;
    logic ordy1;
    logic ordy_rand;
    logic rand_stall;
    int   cyc;

    vedic_mult_seq_ctrl_if bus1 ();
    vedic_mult_seq_ctrl_if bus0 ();

    vedic_mult_seq_ctrl #(.SKIP_ZERO(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    vedic_mult_seq_ctrl #(.SKIP_ZERO(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    assign bus1.out_ready = rand_stall ? ordy_rand : ordy1;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          acyc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   n_cmp;
    int   n_err;
    int   n_acc [2];
    int   n_out [2];
    bit   prev_ov [2];
    int   last_acyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 ordy_rand = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Output monitor: compares every presented product against the queue head
    task automatic mon(input int sel, input logic ov, input logic ir,
                       input logic ordy, input logic [15:0] p);
        exp_t e;
        int   sz;
        if (rst) begin
            prev_ov[sel] = 1'b0;
            return;
        end
        sz = sel ? q1.size() : q0.size();
        if (ov) begin
            chk("ready_valid_exclusive", 32'(ir), 32'd0);
            if (sz == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_out_valid dut%0d: got product %0h expected none", sel, p);
            end else begin
                e = sel ? q1[0] : q0[0];
                if (!prev_ov[sel])
                    chk("latency", 32'(cyc - e.acyc), 32'(e.lat));
                chk("product", 32'(p), 32'(e.prod));
                if (ordy) begin
                    if (sel) void'(q1.pop_front());
                    else     void'(q0.pop_front());
                    n_out[sel]++;
                end
            end
        end
        prev_ov[sel] = ov;
    endtask

    always @(negedge clk) mon(1, bus1.out_valid, bus1.in_ready, bus1.out_ready, bus1.product);
    always @(negedge clk) mon(0, bus0.out_valid, bus0.in_ready, bus0.out_ready, bus0.product);

    // Present one operand pair; push expected result at the acceptance edge
    task automatic send(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit keep);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        if (sel != 0) begin
            bus1.a = a; bus1.b = b; bus1.in_valid = 1'b1;
        end else begin
            bus0.a = a; bus0.b = b; bus0.in_valid = 1'b1;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!rst && ((sel != 0) ? bus1.in_ready : bus0.in_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout dut%0d: got no in_ready expected acceptance", sel);
        end else begin
            e.prod = exp;
            e.lat  = ((sel != 0) && (a == 8'd0 || b == 8'd0)) ? 1 : 4;
            e.acyc = cyc;
            if (sel != 0) q1.push_back(e);
            else          q0.push_back(e);
            last_acyc = cyc;
            n_acc[sel]++;
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (sel != 0) bus1.in_valid = 1'b0;
            else          bus0.in_valid = 1'b0;
        end
    endtask

    task automatic drain(input int sel);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (((sel != 0) ? q1.size() : q0.size()) == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout dut%0d: got %0d pending expected 0", sel,
                     (sel != 0) ? q1.size() : q0.size());
        end
    endtask

    initial begin
        int a1;
        int bl [3];
        bit seen;
        n_cmp = 0; n_err = 0;
        n_acc[0] = 0; n_acc[1] = 0; n_out[0] = 0; n_out[1] = 0;
        cyc = 0;
        rst = 1'b1;
        rand_stall = 1'b0;
        ordy1 = 1'b1;
        ordy_rand = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = 8'd0; bus1.b = 8'd0;
        bus0.in_valid = 1'b0; bus0.a = 8'd0; bus0.b = 8'd0; bus0.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_product", 32'(bus1.product), 32'h0);

        // FF*FF: full latency, in_ready low ADD1..DONE, one-cycle out_valid
        send(1, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_in_ready", 32'(bus1.in_ready), 32'd0);
            chk("busy_out_valid", 32'(bus1.out_valid), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("post_xfer_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("post_xfer_in_ready", 32'(bus1.in_ready), 32'd1);

        // Back-to-back with in_valid held high
        send(1, 8'h12, 8'h34, 16'h03A8, 1'b1);
        a1 = last_acyc;
        send(1, 8'h80, 8'h02, 16'h0100, 1'b0);
        chk("b2b_interval", 32'(last_acyc - a1), 32'd5);
        drain(1);

        // Zero operand: bypass on dut1, full sequence on dut0
        send(1, 8'h00, 8'd200, 16'h0000, 1'b0);
        drain(1);
        send(0, 8'h00, 8'd200, 16'h0000, 1'b0);
        drain(0);
        send(0, 8'hA5, 8'h3C, 16'h26AC, 1'b0);
        drain(0);

        // Backpressure: product held, in_ready low, new operands ignored
        ordy1 = 1'b0;
        send(1, 8'hA5, 8'h3C, 16'h26AC, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bp_out_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus1.a = 8'($urandom);
            bus1.b = 8'($urandom);
            bus1.in_valid = 1'b1;
            @(negedge clk);
            chk("bp_in_ready", 32'(bus1.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus1.out_valid), 32'd1);
            chk("bp_product", 32'(bus1.product), 32'h26AC);
        end
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        ordy1 = 1'b1;
        drain(1);

        // Reset during ADD2 discards the operation
        send(1, 8'hFF, 8'h01, 16'h00FF, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q1.delete();
        n_acc[1]--;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus1.in_ready), 32'd1);
        chk("mid_rst_product", 32'(bus1.product), 32'h0);
        repeat (10) @(negedge clk);

        // Operand sweep with random downstream stalls
        rand_stall = 1'b1;
        for (int a = 0; a < 256; a++) begin
            bl[0] = (a * 37 + 11) & 255;
            bl[1] = 255 - a;
            bl[2] = a;
            for (int k = 0; k < 3; k++)
                send(1, 8'(a), 8'(bl[k]), 16'(a * bl[k]), 1'b0);
        end
        drain(1);
        rand_stall = 1'b0;
        repeat (3) @(negedge clk);

        chk("dut1_out_count", 32'(n_out[1]), 32'(n_acc[1]));
        chk("dut0_out_count", 32'(n_out[0]), 32'(n_acc[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
